// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit (MULTU/MULT/DIVU/DIV) with
//               HI/LO results and fixed, data-independent latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  input  logic             Start_i,
  input  logic [1:0]       Op_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic [WIDTH-1:0] Hi_o,
  output logic [WIDTH-1:0] Lo_o,
  output logic             DivByZero_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNTW-1:0] c_LAST_ITER = CNTW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               w_load;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  // Datapath: accumulator holds {partial product, multiplier} or {remainder, dividend}
  always_comb begin
    w_a_neg   = Op_i[0] & A_i[WIDTH-1];
    w_b_neg   = Op_i[0] & B_i[WIDTH-1];
    w_mag_a   = w_a_neg ? -A_i : A_i;
    w_mag_b   = w_b_neg ? -B_i : B_i;
    w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    w_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, mag_b_q});
    w_rem     = w_ge ? WIDTH'(w_shift - {1'b0, mag_b_q}) : w_shift[WIDTH-1:0];
    w_prod    = neg_res_q ? -acc_q : acc_q;
    w_quo     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    w_rmd     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    mag_b_d   = mag_b_q;
    raw_a_d   = raw_a_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    w_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        w_load = Start_i;
      end
      S_RUN: begin
        acc_d = is_div_q ? {w_rem, acc_q[WIDTH-2:0], w_ge}
                         : {w_mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == c_LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        dbz_d   = is_div_q && (mag_b_q == '0);
        if (!is_div_q) begin
          {hi_d, lo_d} = w_prod;
        end else if (mag_b_q == '0) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else begin
          hi_d = w_rmd;
          lo_d = w_quo;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        w_load  = Start_i;
      end
      default: state_d = S_IDLE;
    endcase

    // Signs are folded in here; the RUN loop only ever sees magnitudes
    if (w_load) begin
      state_d   = S_RUN;
      is_div_d  = Op_i[1];
      mag_b_d   = w_mag_b;
      raw_a_d   = A_i;
      neg_res_d = w_a_neg ^ w_b_neg;
      neg_rem_d = w_a_neg;
      acc_d     = {{WIDTH{1'b0}}, w_mag_a};
      cnt_d     = '0;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      mag_b_q   <= '0;
      raw_a_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      mag_b_q   <= mag_b_d;
      raw_a_q   <= raw_a_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Busy_o      = busy_q;
  assign Done_o      = done_q;
  assign Hi_o        = hi_q;
  assign Lo_o        = lo_q;
  assign DivByZero_o = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit (32-bit and 8-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, dbz;
  logic [W-1:0]  hi, lo;

  logic          start8;
  logic [1:0]    op8;
  logic [7:0]    a8, b8, hi8, lo8;
  logic          busy8, done8, dbz8;

  muldiv_unit #(.WIDTH(W)) u_dut (
    .Clk_i(clk), .Reset_i(rst), .Start_i(start), .Op_i(op), .A_i(a), .B_i(b),
    .Busy_o(busy), .Done_o(done), .Hi_o(hi), .Lo_o(lo), .DivByZero_o(dbz)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .Clk_i(clk), .Reset_i(rst), .Start_i(start8), .Op_i(op8), .A_i(a8), .B_i(b8),
    .Busy_o(busy8), .Done_o(done8), .Hi_o(hi8), .Lo_o(lo8), .DivByZero_o(dbz8)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("dbz", dbz, mon_e.dbz);
        check("latency", cyc, mon_e.due);
      end
    end
  end

  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] p;
    logic [31:0] q, r;
    case (o)
      2'd0: begin
        p = {32'b0, x} * {32'b0, y};
        return {1'b0, p};
      end
      2'd1: begin
        sx = $signed(x);
        sy = $signed(y);
        p  = sx * sy;
        return {1'b0, p};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'd2) return {1'b0, x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // Called at a negedge; Start is sampled at the next posedge (edge e)
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       output int e);
    exp_t t;
    op = o; a = x; b = y; start = 1'b1;
    e = cyc + 1;
    t.hi = eh; t.lo = el; t.dbz = ed; t.due = e + W + 1;
    sb.push_back(t);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_m(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] r;
    int          e;
    r = model(o, x, y);
    issue(o, x, y, r[63:32], r[31:0], r[64], e);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int e;
    int t;
    int d0;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_dbz", dbz, 0);

    // MULTU with Busy profile
    issue(2'd0, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, e);
    for (int k = 0; k <= W; k++) begin
      check("busy_run", busy, 1);
      @(negedge clk);
    end
    check("busy_done", busy, 0);
    check("done_pulse", done, 1);
    drain();

    issue(2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, e); drain();
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, e); drain();
    issue(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, e); drain();
    issue(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, e); drain();
    issue(2'd2, 32'd1234, 32'd64, 32'd18, 32'd19, 1'b0, e); drain();
    issue(2'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, e); drain();
    check("dbz_hold", dbz, 1);
    issue(2'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, e); drain();

    // Start while busy is ignored, then back-to-back issue from the Done cycle
    issue(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, e);
    repeat (9) @(negedge clk);
    op = 2'd2; a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_done", done, 1);
    issue(2'd2, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, e);
    drain();

    // Model-checked vectors across all ops
    for (int i = 0; i < 8; i++) begin
      issue_m(2'(i % 4), $urandom, (i > 4) ? 32'($urandom_range(1, 300)) : $urandom);
      drain();
    end
    issue_m(2'd3, 32'h8000_0000, 32'd3); drain();
    issue_m(2'd1, 32'h8000_0000, 32'h8000_0000); drain();

    // Reset mid-operation discards the operation
    issue(2'd3, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, e);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hilo", {hi, lo}, 0);
    d0 = n_done;
    repeat (40) @(negedge clk);
    check("midrst_no_done", 64'(n_done - d0), 0);

    // Reset wins over a simultaneous Start
    rst = 1'b1; start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("rst_start_no_done", 64'(n_done - d0), 0);

    // 8-bit instance
    op8 = 2'd0; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    t = 0;
    while (!done8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("w8_done", done8, 1);
    check("w8_latency", cyc, e + 9);
    check("w8_hi", hi8, 8'hFE);
    check("w8_lo", lo8, 8'h01);
    check("w8_dbz", dbz8, 0);
    @(negedge clk);
    check("w8_idle", busy8, 0);

    check("sb_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
